// File: rtl/lcd_write_sequencer_if.sv
// Client write port of the character-LCD sequencer.
// The client (master) presents {rs, byte} with valid and holds it until
// ready is seen high on the same cycle; the sequencer (slave) owns ready.
interface lcd_write_sequencer_if;
  logic       wr_valid;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (
    output wr_valid,
    output wr_rs,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_rs,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/lcd_write_sequencer.sv
// Character-LCD write sequencer (4-bit bus).
// After reset it waits for the panel to power up, runs the 4-bit init
// nibbles and the configuration bytes 0x28/0x06/0x0C/0x01, then accepts
// {rs, byte} writes from a client and sends each as two timed nibbles.
// Every wait is driven by one shared down-counter: a state that holds for
// N cycles loads N-1 on entry and leaves on the edge where it reads 0.
// Gaps that follow a complete nibble/byte (init gaps, post-byte wait) are
// measured from the falling edge of e, so they include the 1-cycle hold.
// The gap between the two nibbles of one byte starts after the hold.
//
// Optional feature: define LCD_AUTO_WRAP_EN to track the cursor and insert
// a line-change command (0xC0 / 0x80) after the 16th data byte on a line.
module lcd_write_sequencer #(
  parameter int SETUP_CYC     = 2,
  parameter int E_HIGH_CYC    = 12,
  parameter int NIB_GAP_CYC   = 50,
  parameter int BYTE_GAP_CYC  = 2000,
  parameter int CLEAR_CYC     = 82000,
  parameter int PWRON_CYC     = 750000,
  parameter int INIT_GAP0_CYC = 205000,
  parameter int INIT_GAP1_CYC = 5000,
  parameter int INIT_GAP2_CYC = 2000
) (
  input  logic                  clk,
  input  logic                  reset,
  lcd_write_sequencer_if.slave  wr,
  output logic                  init_done,
  output logic                  sf_e,
  output logic                  e,
  output logic                  rs,
  output logic                  rw,
  output logic                  d,
  output logic                  c,
  output logic                  b,
  output logic                  a
);

  // The sum of all waits is a safe upper bound for any single wait.
  localparam int CNT_W = $clog2(SETUP_CYC + E_HIGH_CYC + NIB_GAP_CYC +
                                BYTE_GAP_CYC + CLEAR_CYC + PWRON_CYC +
                                INIT_GAP0_CYC + INIT_GAP1_CYC +
                                INIT_GAP2_CYC + 1);

  typedef enum logic [2:0] {
    PWR_WAIT,
    NIB_SETUP,
    NIB_HIGH,
    NIB_HOLD,
    NIB_GAP,
    POST_WAIT,
    IDLE
  } state_t;

  // What the nibble engine is currently sending on behalf of.
  typedef enum logic [1:0] {
    PH_INIT,
    PH_CFG,
    PH_USER,
    PH_WRAP
  } phase_t;

  state_t           state_q;
  phase_t           phase_q;
  logic [CNT_W-1:0] cnt_q;
  logic             armed_q;
  logic [1:0]       idx_q;
  logic             lowNib_q;
  logic [7:0]       byte_q;
  logic             rsLat_q;
  logic             e_q;
  logic             rs_q;
  logic [3:0]       nib_q;
  logic             ready_q;
  logic             initDone_q;
  logic             sfE_q;

`ifdef LCD_AUTO_WRAP_EN
  logic [3:0]       col_q;
  logic             line_q;
`endif

  logic             isClear;
  logic [CNT_W-1:0] postLoad;

  function automatic logic [CNT_W-1:0] ld(input int n);
    return CNT_W'(n - 1);
  endfunction

  function automatic logic [7:0] cfgByte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  assign isClear = !rsLat_q && (byte_q == 8'h01 || byte_q == 8'h02);

  // Wait length after a finished init nibble or byte, counted from e falling.
  always_comb begin
    postLoad = CNT_W'(BYTE_GAP_CYC - 2);
    if (phase_q == PH_INIT) begin
      case (idx_q)
        2'd0:    postLoad = CNT_W'(INIT_GAP0_CYC - 2);
        2'd1:    postLoad = CNT_W'(INIT_GAP1_CYC - 2);
        default: postLoad = CNT_W'(INIT_GAP2_CYC - 2);
      endcase
    end else if (isClear) begin
      postLoad = CNT_W'(CLEAR_CYC - 2);
    end
  end

  // Sequencer FSM: power-up wait, init, config, client writes; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= PWR_WAIT;
      phase_q    <= PH_INIT;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      idx_q      <= 2'd0;
      lowNib_q   <= 1'b0;
      byte_q     <= 8'h00;
      rsLat_q    <= 1'b0;
      e_q        <= 1'b0;
      rs_q       <= 1'b0;
      nib_q      <= 4'h0;
      ready_q    <= 1'b0;
      initDone_q <= 1'b0;
      sfE_q      <= 1'b1;
`ifdef LCD_AUTO_WRAP_EN
      col_q      <= 4'd0;
      line_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        PWR_WAIT: begin
          if (!armed_q) begin
            armed_q <= 1'b1;
            cnt_q   <= CNT_W'(PWRON_CYC - 2);
          end else if (cnt_q == '0) begin
            state_q <= NIB_SETUP;
            cnt_q   <= ld(SETUP_CYC);
            phase_q <= PH_INIT;
            idx_q   <= 2'd0;
            rs_q    <= 1'b0;
            nib_q   <= 4'h3;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        NIB_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= NIB_HIGH;
            cnt_q   <= ld(E_HIGH_CYC);
            e_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        NIB_HIGH: begin
          if (cnt_q == '0) begin
            state_q <= NIB_HOLD;
            cnt_q   <= '0;
            e_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        NIB_HOLD: begin
          if (phase_q != PH_INIT && !lowNib_q) begin
            state_q <= NIB_GAP;
            cnt_q   <= ld(NIB_GAP_CYC);
          end else begin
            state_q <= POST_WAIT;
            cnt_q   <= postLoad;
          end
        end

        NIB_GAP: begin
          if (cnt_q == '0) begin
            state_q  <= NIB_SETUP;
            cnt_q    <= ld(SETUP_CYC);
            lowNib_q <= 1'b1;
            nib_q    <= byte_q[3:0];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        POST_WAIT: begin
          if (cnt_q == '0) begin
            case (phase_q)
              PH_INIT: begin
                if (idx_q == 2'd3) begin
                  phase_q  <= PH_CFG;
                  idx_q    <= 2'd0;
                  state_q  <= NIB_SETUP;
                  cnt_q    <= ld(SETUP_CYC);
                  lowNib_q <= 1'b0;
                  byte_q   <= cfgByte(2'd0);
                  rsLat_q  <= 1'b0;
                  rs_q     <= 1'b0;
                  nib_q    <= cfgByte(2'd0) >> 4;
                end else begin
                  idx_q   <= idx_q + 2'd1;
                  state_q <= NIB_SETUP;
                  cnt_q   <= ld(SETUP_CYC);
                  nib_q   <= (idx_q == 2'd2) ? 4'h2 : 4'h3;
                end
              end

              PH_CFG: begin
                if (idx_q == 2'd3) begin
                  state_q    <= IDLE;
                  ready_q    <= 1'b1;
                  initDone_q <= 1'b1;
                end else begin
                  idx_q    <= idx_q + 2'd1;
                  state_q  <= NIB_SETUP;
                  cnt_q    <= ld(SETUP_CYC);
                  lowNib_q <= 1'b0;
                  byte_q   <= cfgByte(idx_q + 2'd1);
                  rsLat_q  <= 1'b0;
                  rs_q     <= 1'b0;
                  nib_q    <= cfgByte(idx_q + 2'd1) >> 4;
                end
              end

              PH_USER: begin
`ifdef LCD_AUTO_WRAP_EN
                if (rsLat_q && col_q == 4'd15) begin
                  col_q    <= 4'd0;
                  line_q   <= ~line_q;
                  phase_q  <= PH_WRAP;
                  state_q  <= NIB_SETUP;
                  cnt_q    <= ld(SETUP_CYC);
                  lowNib_q <= 1'b0;
                  byte_q   <= line_q ? 8'h80 : 8'hC0;
                  rsLat_q  <= 1'b0;
                  rs_q     <= 1'b0;
                  nib_q    <= line_q ? 4'h8 : 4'hC;
                end else begin
                  if (rsLat_q) begin
                    col_q <= col_q + 4'd1;
                  end else if (isClear) begin
                    col_q  <= 4'd0;
                    line_q <= 1'b0;
                  end else if (byte_q[7]) begin
                    col_q  <= byte_q[3:0];
                    line_q <= byte_q[6];
                  end
                  state_q    <= IDLE;
                  ready_q    <= 1'b1;
                  initDone_q <= 1'b1;
                end
`else
                state_q    <= IDLE;
                ready_q    <= 1'b1;
                initDone_q <= 1'b1;
`endif
              end

              default: begin
                state_q    <= IDLE;
                ready_q    <= 1'b1;
                initDone_q <= 1'b1;
              end
            endcase
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        IDLE: begin
          if (wr.wr_valid && ready_q) begin
            ready_q  <= 1'b0;
            phase_q  <= PH_USER;
            state_q  <= NIB_SETUP;
            cnt_q    <= ld(SETUP_CYC);
            lowNib_q <= 1'b0;
            byte_q   <= wr.wr_data;
            rsLat_q  <= wr.wr_rs;
            rs_q     <= wr.wr_rs;
            nib_q    <= wr.wr_data[7:4];
          end
        end

        default: begin
          state_q <= PWR_WAIT;
          armed_q <= 1'b0;
          cnt_q   <= '0;
          e_q     <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr.wr_ready  = ready_q;
  assign init_done    = initDone_q;
  assign sf_e         = sfE_q;
  assign e            = e_q;
  assign rs           = rs_q;
  assign rw           = 1'b0;
  assign {d, c, b, a} = nib_q;

endmodule
